prog_dumper: RTL

PROG_DUMPER -- requirements
Module: prog_dumper

---
 rtl/prog_dumper.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/prog_dumper.sv
// Memory dumper: reads a range of bytes over a simple read strobe and sends each byte,
// followed by an 8-bit additive checksum, as 8N1 UART frames gated by the host's CTS.
module prog_dumper #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned READ_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        start,
  input  logic [20:0] first_adr,
  input  logic [21:0] count,
  output logic [20:0] adr,
  output logic        read,
  input  logic [7:0]  data,
  input  logic        cts_in,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned TmrW = $clog2(CLKS_PER_BIT);
  localparam int unsigned RdW  = (READ_CYCLES > 1) ? $clog2(READ_CYCLES) : 1;

  localparam logic [TmrW-1:0] TmrLast  = TmrW'(CLKS_PER_BIT - 1);
  localparam logic [RdW-1:0]  RdLast   = RdW'(READ_CYCLES - 1);
  localparam logic [21:0]     MaxCount = 22'h200000;
  localparam logic [3:0]      StopIdx  = 4'd9;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StTx,
    StNext,
    StSum,
    StFin
  } state_e;

  state_e          r_state;
  state_e          w_state_next;

  logic [20:0]     r_adr;
  logic [21:0]     r_remaining;
  logic [7:0]      r_sum;
  logic [7:0]      r_byte;
  logic            r_last;
  logic [RdW-1:0]  r_rd_cnt;
  logic [TmrW-1:0] r_bit_tmr;
  logic [3:0]      r_bit_idx;

  logic [21:0]     w_count;
  logic            w_rd_last;
  logic            w_bit_end;
  logic            w_frame_end;
  logic [3:0]      w_idx_m1;

  assign w_count     = (count > MaxCount) ? MaxCount : count;
  assign w_rd_last   = (r_rd_cnt == RdLast);
  assign w_bit_end   = (r_bit_tmr == TmrLast);
  assign w_frame_end = w_bit_end && (r_bit_idx == StopIdx);
  assign w_idx_m1    = r_bit_idx - 4'd1;
  assign adr         = r_adr;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_next = (w_count != 22'd0) ? StRead : StWait;
        end
      end
      StRead: begin
        if (w_rd_last) begin
          w_state_next = StWait;
        end
      end
      StWait: begin
        if (cts_in) begin
          w_state_next = StTx;
        end
      end
      StTx: begin
        if (w_frame_end) begin
          w_state_next = r_last ? StFin : StNext;
        end
      end
      StNext: begin
        w_state_next = (r_remaining != 22'd1) ? StRead : StSum;
      end
      StSum: begin
        w_state_next = StWait;
      end
      StFin: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    read = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      StIdle: begin
        busy = 1'b0;
      end
      StRead: begin
        read = 1'b1;
        busy = 1'b1;
      end
      StTx: begin
        busy = 1'b1;
        if (r_bit_idx == 4'd0) begin
          tx = 1'b0;
        end else if (r_bit_idx <= 4'd8) begin
          tx = r_byte[w_idx_m1[2:0]];
        end
      end
      StWait, StNext, StSum: begin
        busy = 1'b1;
      end
      StFin: begin
        done = 1'b1;
      end
    endcase
  end

  // r_adr is loaded only on the way into READ, so adr holds between accesses.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_adr       <= '0;
      r_remaining <= '0;
      r_sum       <= '0;
      r_byte      <= '0;
      r_last      <= 1'b0;
      r_rd_cnt    <= '0;
      r_bit_tmr   <= '0;
      r_bit_idx   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_remaining <= w_count;
            r_sum       <= '0;
            r_byte      <= '0;
            r_last      <= (w_count == 22'd0);
            r_rd_cnt    <= '0;
            if (w_count != 22'd0) begin
              r_adr <= first_adr;
            end
          end
        end
        StRead: begin
          if (w_rd_last) begin
            r_rd_cnt <= '0;
            r_byte   <= data;
            r_sum    <= r_sum + data;
          end else begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
          end
        end
        StWait: begin
          r_bit_tmr <= '0;
          r_bit_idx <= '0;
        end
        StTx: begin
          if (w_bit_end) begin
            r_bit_tmr <= '0;
            r_bit_idx <= w_frame_end ? 4'd0 : r_bit_idx + 4'd1;
          end else begin
            r_bit_tmr <= r_bit_tmr + 1'b1;
          end
        end
        StNext: begin
          r_remaining <= r_remaining - 22'd1;
          if (r_remaining != 22'd1) begin
            r_adr <= r_adr + 21'd1;
          end
        end
        StSum: begin
          r_byte <= r_sum;
          r_last <= 1'b1;
        end
        StFin: begin
          r_last <= 1'b0;
        end
      endcase
    end
  end

endmodule
